logic_unit_arbiter: RTL
=======================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: LU_LAT, default 3, cycles from issue on lu_a/lu_b/lu_op to result valid on lu_out; legal range 1..8.
REQ-002 Parameter: NREQ, default 2, number of requesters; fixed at 2 in this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  2  per-requester operation request.
REQ-006 req_ready  output  2  per-requester grant; a transfer occurs when valid and ready are both high on a clock edge.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  32 each  operands of requester 0 and requester 1.
REQ-008 req_op0, req_op1  input  3 each  operation codes of requester 0 and requester 1.
REQ-009 lu_a, lu_b  output  32 each  operands driven to the shared logic unit.
REQ-010 lu_op  output  3  operation code driven to the shared logic unit.
REQ-011 lu_out  input  32  logic unit result, valid LU_LAT cycles after issue.
REQ-012 rsp_valid  output  2  one-cycle result strobe per requester; rsp_valid has no backpressure.
REQ-013 rsp_data  output  32  result data, qualified by rsp_valid.
REQ-014 busy  output  1  high while any issued operation is in flight.
REQ-015 inflight  output  4  count of operations in flight.

Function
REQ-016 Op encoding: op[2:1] selects 00 AND, 01 OR, 10 XOR, 11 pass-A; op[0]=1 inverts the result; the arbiter forwards op unmodified.
REQ-017 Arbitration: round-robin; a 1-bit priority pointer names the favoured requester; reset value 0.
REQ-018 When exactly one requester is valid, it is granted; when both are valid, the requester named by the pointer is granted.
REQ-019 After each grant the pointer is set to the requester not granted; the pointer holds on idle cycles.
REQ-020 req_ready is combinational from req_valid and the pointer; at most one bit is high; ready is never high without the matching valid.
REQ-021 One operation is issued per cycle at most; there are no stall cycles, so both valid every cycle yields an alternating 0,1,0,1 grant sequence.
REQ-022 lu_a, lu_b and lu_op are combinationally muxed from the granted requester; they are driven to 0 when no grant occurs.
REQ-023 Tag pipeline: LU_LAT stages of {valid, id}; stage 0 loads {grant, granted id}; all stages shift every cycle.
REQ-024 When the final stage is valid, rsp_valid[id]=1 and rsp_data=lu_out in that cycle; otherwise rsp_valid=0 and rsp_data=0.
REQ-025 Results return in issue order; the latency from transfer edge to rsp_valid is exactly LU_LAT cycles.
REQ-026 inflight = number of valid tag stages; busy = (inflight != 0).
REQ-027 A simultaneous issue and retire in one cycle leaves inflight unchanged.
REQ-028 inflight never exceeds LU_LAT.

Reset
REQ-029 While rst_n=0: all tag stages invalid, pointer=0, rsp_valid=0, rsp_data=0, busy=0, inflight=0, and req_ready=0.
REQ-030 Reset mid-operation discards every in-flight result; no rsp_valid is produced for operations issued before reset.
REQ-031 The first grant is possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package holds the op-field constants (OP_AND, OP_OR, OP_XOR, OP_PASS, OP_INV bit position), the data width of 32, and the default of LU_LAT.
REQ-033 Sub-module lu_tag_pipe: a parameterised LU_LAT-deep {valid, id} shift register with an occupancy count.
REQ-034 The logic unit itself is instantiated outside this block, at the next level up.

Verification
REQ-035 Only req0 valid with a=0xF0F0F0F0, b=0xFF00FF00, op=000 -> rsp_valid[0] exactly 3 cycles later with rsp_data=0xF000F000.
REQ-036 Both requesters valid for 4 cycles -> grants 0,1,0,1; rsp_valid sequence 01,10,01,10 starting cycle 3; inflight reaches 3.
REQ-037 req1 op=111 with a=0x12345678 -> rsp_data=0xEDCBA987 on rsp_valid[1].
REQ-038 Reset pulse while inflight=2 -> no rsp_valid afterward, inflight=0, pointer=0, and the next dual request grants requester 0.
REQ-039 Idle gap: grant req0, 2 idle cycles, then both valid -> req1 granted first; lu_a/lu_b/lu_op are 0 during the idle cycles.
REQ-040 Run with LU_LAT=1 -> response in the cycle after transfer; back-to-back issue holds inflight=1.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the two-requester logic-unit arbiter: op field layout,
// datapath width and the default logic-unit latency.
package logic_unit_arbiter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned LU_LAT_DEF = 3;
  localparam int unsigned INFLT_W    = 4;

  // op[2:1] selects the function, op[OP_INV] inverts the result
  localparam int unsigned OP_INV = 0;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } lu_fn_e;

endpackage

// File: rtl/logic_unit_arbiter_tag_pipe.sv
// LU_LAT-deep {valid, id} shift register that tracks operations in flight
// through the external logic unit, with an occupancy count.
module lu_tag_pipe
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned LU_LAT = LU_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_id,
  output logic               out_valid,
  output logic               out_id,
  output logic [INFLT_W-1:0] count
);

  logic [LU_LAT-1:0] vld;
  logic [LU_LAT-1:0] id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      id    <= '0;
      count <= '0;
    end else begin
      vld[0] <= in_valid;
      id[0]  <= in_id;
      for (int unsigned i = 1; i < LU_LAT; i++) begin
        vld[i] <= vld[i-1];
        id[i]  <= id[i-1];
      end
      // issue and retire in the same cycle cancel out
      count <= count + INFLT_W'(in_valid) - INFLT_W'(vld[LU_LAT-1]);
    end
  end

  assign out_valid = vld[LU_LAT-1];
  assign out_id    = id[LU_LAT-1];

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one pipelined logic unit between two requesters;
// results are routed back to the issuing requester after LU_LAT cycles.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned LU_LAT = LU_LAT_DEF,
  parameter int unsigned NREQ   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [DATA_W-1:0]   req_a0,
  input  logic [DATA_W-1:0]   req_b0,
  input  logic [OP_W-1:0]     req_op0,
  input  logic [DATA_W-1:0]   req_a1,
  input  logic [DATA_W-1:0]   req_b1,
  input  logic [OP_W-1:0]     req_op1,
  output logic [DATA_W-1:0]   lu_a,
  output logic [DATA_W-1:0]   lu_b,
  output logic [OP_W-1:0]     lu_op,
  input  logic [DATA_W-1:0]   lu_out,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy,
  output logic [INFLT_W-1:0]  inflight
);

  logic ptr;
  logic grant;
  logic grant_id;
  logic ret_valid;
  logic ret_id;

  // ready is gated by rst_n so nothing is granted while reset is held
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (req_valid[0] && req_valid[1]) req_ready[ptr] = 1'b1;
      else                              req_ready     = req_valid;
    end
  end

  assign grant    = |req_ready;
  assign grant_id = req_ready[1];

  always_comb begin
    lu_a  = '0;
    lu_b  = '0;
    lu_op = '0;
    if (req_ready[0]) begin
      lu_a  = req_a0;
      lu_b  = req_b0;
      lu_op = req_op0;
    end else if (req_ready[1]) begin
      lu_a  = req_a1;
      lu_b  = req_b1;
      lu_op = req_op1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= 1'b0;
    else if (grant) ptr <= ~grant_id;
  end

  lu_tag_pipe #(.LU_LAT(LU_LAT)) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (grant),
    .in_id     (grant_id),
    .out_valid (ret_valid),
    .out_id    (ret_id),
    .count     (inflight)
  );

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (ret_valid) begin
      rsp_valid[ret_id] = 1'b1;
      rsp_data          = lu_out;
    end
  end

  assign busy = (inflight != '0);

endmodule
